// File: rtl/div_unit.sv
// Multi-cycle restoring integer divider for the EX stage (DIV/DIVU).
// Produces {remainder, quotient}; start/ready handshake with annul on flush.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {FREE, ZERO, ON, END} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W:0]   w;
  logic [DATA_W-1:0]   divisor;
  logic                neg_q;
  logic                neg_r;

  logic [DATA_W-1:0]   mag1;
  logic [DATA_W-1:0]   mag2;
  logic [DATA_W:0]     diff;
  logic [2*DATA_W:0]   w_next;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;

  always_comb begin
    mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    // Trial subtraction on the upper half; borrow out (diff msb) means restore.
    diff   = {1'b0, w[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
    w_next = diff[DATA_W] ? {w[2*DATA_W-1:0], 1'b0}
                          : {diff[DATA_W-1:0], w[DATA_W-1:0], 1'b1};
    quo = neg_q ? -w[DATA_W-1:0]        : w[DATA_W-1:0];
    rem = neg_r ? -w[2*DATA_W:DATA_W+1] : w[2*DATA_W:DATA_W+1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      w        <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= ZERO;
            end else begin
              state   <= ON;
              cnt     <= '0;
              w       <= {{DATA_W{1'b0}}, mag1, 1'b0};
              divisor <= mag2;
              neg_q   <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              neg_r   <= signed_div_i && opdata1_i[DATA_W-1];
            end
          end
        end
        ZERO: begin
          state    <= END;
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        ON: begin
          if (annul_i) begin
            state    <= FREE;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else if (cnt != CNT_W'(DATA_W)) begin
            w   <= w_next;
            cnt <= cnt + CNT_W'(1);
          end else begin
            state    <= END;
            result_o <= {rem, quo};
            ready_o  <= 1'b1;
          end
        end
        END: begin
          if (!start_i) begin
            state    <= FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Randomized bench for div_unit: cycle-accurate expected outputs from a
// plain-arithmetic division model, compared on every falling edge.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks;
  int n_fail;
  bit checking;
  logic        exp_ready;
  logic [63:0] exp_result;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Division semantics: magnitude divide, quotient sign = XOR of signs,
  // remainder sign = dividend sign, divide-by-zero yields all zero.
  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return 64'd0;
    ma = (s && a[31]) ? 32'd0 - a : a;
    mb = (s && b[31]) ? 32'd0 - b : b;
    q = ma / mb;
    r = ma % mb;
    if (s && (a[31] ^ b[31])) q = 32'd0 - q;
    if (s && a[31]) r = 32'd0 - r;
    return {r, q};
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      n_checks++;
      if (ready_o !== exp_ready || result_o !== exp_result) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t: ready=%b result=%h, expected ready=%b result=%h",
                 $time, ready_o, result_o, exp_ready, exp_result);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom);
  endtask

  // Called just after a posedge with the DUT in FREE. Optional literal pin.
  task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit zannul,
                       input bit use_lit, input logic [63:0] lit, input string name);
    logic [63:0] exp;
    int lat;
    exp = model(s, a, b);
    lat = (b == 32'd0) ? 2 : 34;
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    tick();                       // E0
    scramble();
    if (b == 32'd0) annul_i = zannul;
    repeat (lat - 2) tick();
    tick();                       // ready_o becomes visible after this edge
    annul_i    = 1'b0;
    exp_ready  = 1'b1;
    exp_result = exp;
    if (use_lit) check64(name, result_o, lit);
    repeat (hold) begin
      scramble();
      tick();
    end
    start_i = 1'b0;
    tick();
    exp_ready  = 1'b0;
    exp_result = 64'd0;
  endtask

  initial begin
    logic [31:0] a, b;
    int r;
    n_checks = 0; n_fail = 0; checking = 1'b0;
    exp_ready = 1'b0; exp_result = 64'd0;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
    signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    tick();
    checking = 1'b1;
    tick(); tick();
    check64("reset_state", {result_o[62:0], ready_o}, 64'd0);
    rst = 1'b0;
    tick();

    // Pin the model with hand-computed values.
    check64("model_u100_7", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    check64("model_s-100_7", model(1'b1, -32'sd100, 32'd7), {32'hFFFFFFFE, 32'hFFFFFFF2});
    check64("model_s100_-7", model(1'b1, 32'd100, -32'sd7), {32'h00000002, 32'hFFFFFFF2});
    check64("model_min_-1", model(1'b1, 32'h80000000, 32'hFFFFFFFF), {32'd0, 32'h80000000});

    do_op(1'b0, 32'd100, 32'd7, 3, 1'b0, 1'b1, {32'd2, 32'd14}, "u100_7");
    do_op(1'b1, -32'sd100, 32'd7, 0, 1'b0, 1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, "s-100_7");
    do_op(1'b1, 32'd100, -32'sd7, 1, 1'b0, 1'b1, {32'h00000002, 32'hFFFFFFF2}, "s100_-7");
    do_op(1'b0, 32'd5, 32'd0, 2, 1'b0, 1'b1, 64'd0, "u5_0");
    do_op(1'b1, 32'd5, 32'd0, 0, 1'b1, 1'b1, 64'd0, "s5_0_annul_ignored");
    do_op(1'b0, 32'hFFFFFFFF, 32'd1, 1, 1'b0, 1'b1, {32'd0, 32'hFFFFFFFF}, "umax_1");
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, 1'b1, {32'd0, 32'h80000000}, "smin_-1");
    do_op(1'b0, 32'd0, 32'd9, 0, 1'b0, 1'b1, 64'd0, "zero_9");

    // annul together with start in FREE: no start
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    repeat (3) tick();
    annul_i = 1'b0; start_i = 1'b0;
    tick();

    // annul at E10, then immediate restart
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    tick();                       // E0
    repeat (9) tick();            // E1..E9
    annul_i = 1'b1;
    tick();                       // E10
    annul_i = 1'b0;
    do_op(1'b0, 32'd1000, 32'd3, 1, 1'b0, 1'b1, {32'd1, 32'd333}, "after_annul");

    // synchronous reset at E20
    opdata1_i = 32'd777; opdata2_i = 32'd4; start_i = 1'b1;
    tick();
    repeat (19) tick();
    rst = 1'b1; start_i = 1'b0;
    tick();                       // E20
    rst = 1'b0;
    do_op(1'b1, -32'sd1000, 32'd3, 0, 1'b0, 1'b1, {32'hFFFFFFFF, 32'hFFFFFEB3}, "after_reset");

    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 9);
      a = (r == 9) ? 32'h80000000 : $urandom;
      case (r)
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'd0 - $urandom_range(1, 15);
        3: b = 32'hFFFFFFFF;
        4: b = 32'd1;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      do_op(1'($urandom), a, b, $urandom_range(0, 2), 1'b0, 1'b0, 64'd0, "rand");
    end

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider in the EX stage.
- Consumes the operand pair and the DIV/DIVU decode that the ID/EX register delivers.
- Returns a 64-bit {remainder, quotient} to EX for HI/LO writeback.
- Start/ready handshake: EX requests pipeline stall while busy; an annul input cancels an in-flight divide on flush.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- signed_div_i  input  1  1 = signed DIV, 0 = DIVU
- opdata1_i  input  32  dividend
- opdata2_i  input  32  divisor
- start_i  input  1  request; held high by EX until ready_o is seen
- annul_i  input  1  cancel current operation (pipeline flush)
- result_o  output  64  [63:32] remainder, [31:0] quotient
- ready_o  output  1  result valid

Behaviour:
- Outputs are registered.
- rst (sampled at posedge clk) forces:
  - state FREE, counter 0, internal dividend/divisor registers 0, result_o 0, ready_o 0.
  - Reset overrides everything, including mid-operation.
- States: FREE, ZERO, ON, END.
- FREE:
  - start_i=1 & annul_i=0 at edge E0, opdata2_i==0 -> ZERO.
  - start_i=1 & annul_i=0 at edge E0, opdata2_i!=0 -> ON, counter=0.
  - In the ON case, operands are captured at E0. For signed_div_i=1, magnitudes are captured (two's-complement negate when bit 31 set); original signs are recorded.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- ZERO:
  - At E1 -> END, result_o=0, ready_o=1. annul_i is ignored in this state.
- ON:
  - annul_i=1 at any edge -> FREE, counter 0, ready_o 0, result_o 0.
  - Otherwise, edges E1..E32 each perform one restoring step on a 65-bit working register W.
    - W initialised at E0 to {32'b0, dividend, 1'b0}.
    - diff = W[63:32] - divisor, computed as 33-bit.
    - If diff is negative: W = W << 1.
    - Else: W = {diff[31:0], W[31:0], 1'b1}.
    - counter increments each step.
  - At E33 (counter==32) -> END, ready_o=1.
    - Quotient = W[31:0]; remainder = W[64:33].
    - Signed fix-up: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Latency: ready_o is visible in the cycle after E33, i.e. 33 cycles after the accepting edge.
- END:
  - result_o and ready_o hold while start_i=1.
  - start_i=0 at an edge -> FREE; at that edge ready_o=0 and result_o=0.
  - A new request needs at least one FREE cycle, so there are no back-to-back starts from END.
- Inputs opdata1_i, opdata2_i and signed_div_i are don't-care after E0; changes must not affect the result.
- annul_i and start_i both high in FREE: annul wins, no start.
- Arithmetic wraps modulo 2^32. Signed 0x80000000 / -1 gives quotient 0x80000000 and remainder 0; there is no exception.

Test Plan:
- Unsigned 100 / 7 -> ready_o rises 33 cycles after start accept; result_o = {32'd2, 32'd14}. ready_o/result_o hold while start_i=1; both clear one edge after start_i drops.
- Signed -100 / 7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE. Signed 100 / -7 -> quotient 0xFFFFFFF2, remainder 0x00000002.
- 5 / 0, either signedness -> ready_o after 2 edges (E1 -> END); result_o = 0.
- Corner values:
  - DIVU 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
  - DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
  - 0 / 9 -> all zero.
- Annul: start 1000/3, assert annul_i at E10 -> FREE, ready_o 0, result_o 0 next cycle. Immediate new start 1000/3 -> {1, 333}, 33 cycles later.
- Reset mid-operation at E20 -> all outputs 0, state FREE. Operand changes after E0 (random) do not alter the result; compare against a reference model over 1000 random signed/unsigned pairs.
